// File: rtl/fast_command_executor.sv
// -----------------------------------------------------------------------------
// fast_command_executor
//   Acts on the fast-command decoder output in the 40 MHz domain. Inputs are
//   registered once; every action lands on the outputs one clk40 cycle later.
//
//   Ports:
//     clk40, reset        40 MHz clock, async active-high reset
//     aligned             decoder alignment achieved (gates all commands)
//     invalidCmd          decoder saw a non-command symbol
//     fcd[9:0]            one-hot command word
//     bcid[11:0]          bunch-crossing counter (wraps at BCID_MAX)
//     bcidSynced          a BCR / L1A_BCR has executed since reset/alignment loss
//     l1a, linkReset,
//     syncForTrig         single-cycle strobes
//     l1aCount[7:0]       L1A event counter (wrapping)
//     qinj, qinjBusy      delayed charge-injection pulse / pending flag
//     wsActive            waveform-sampler window level
//     errCount[7:0]       saturating command-error counter
// -----------------------------------------------------------------------------
module fast_command_executor #(
    parameter int BCID_MAX    = 3563,
    parameter int BCID_OFFSET = 0,
    parameter int QINJ_DELAY  = 4
) (
    input  logic        clk40,
    input  logic        reset,
    input  logic        aligned,
    input  logic        invalidCmd,
    input  logic [9:0]  fcd,
    output logic [11:0] bcid,
    output logic        bcidSynced,
    output logic        l1a,
    output logic [7:0]  l1aCount,
    output logic        linkReset,
    output logic        syncForTrig,
    output logic        qinj,
    output logic        qinjBusy,
    output logic        wsActive,
    output logic [7:0]  errCount
);

    typedef enum logic {QIDLE = 1'b0, QWAIT = 1'b1} qstate_t;

    // Command bit positions
    localparam int C_IDLE   = 0;
    localparam int C_LRST   = 1;
    localparam int C_BCR    = 2;
    localparam int C_SYNC   = 3;
    localparam int C_L1ACR  = 4;
    localparam int C_QINJ   = 5;
    localparam int C_L1A    = 6;
    localparam int C_L1ABCR = 7;
    localparam int C_WSSTA  = 8;
    localparam int C_WSSTP  = 9;

    // Input stage
    logic       aligned_q, aligned_prev_q, inv_q;
    logic [9:0] fcd_q;

    // State
    logic [11:0] bcid_q, bcid_d;
    logic        synced_q, synced_d;
    logic        l1a_q, l1a_d;
    logic [7:0]  l1acnt_q, l1acnt_d;
    logic        lrst_q, lrst_d;
    logic        sync_q, sync_d;
    logic        qinj_q, qinj_d;
    logic        ws_q, ws_d;
    logic [7:0]  err_q, err_d;
    qstate_t     qst_q, qst_d;
    logic [3:0]  qcnt_q, qcnt_d;

    logic       one_hot, multi_hot, align_fall, bc_load, ci_err, err_event;
    logic [9:0] cmd;

    // fcd_q & (fcd_q-1) clears the lowest set bit; zero result means <=1 bit set.
    assign one_hot    = (fcd_q != '0) && ((fcd_q & (fcd_q - 10'd1)) == '0);
    assign multi_hot  = (fcd_q != '0) && !one_hot;
    assign cmd        = (aligned_q && one_hot) ? fcd_q : '0;
    assign align_fall = aligned_prev_q && !aligned_q;
    assign bc_load    = cmd[C_BCR] || cmd[C_L1ABCR];

    // IDLE takes no action; the bit is decoded only to keep it out of the
    // malformed-command check.
    logic unused_idle;
    assign unused_idle = cmd[C_IDLE];

    // Charge-injection FSM
    always_comb begin
        qst_d  = qst_q;
        qcnt_d = qcnt_q;
        qinj_d = 1'b0;
        ci_err = 1'b0;
        if (align_fall) begin
            // Abandon any pending injection silently.
            qst_d  = QIDLE;
            qcnt_d = '0;
        end else begin
            case (qst_q)
                QIDLE: begin
                    if (cmd[C_QINJ]) begin
                        qst_d  = QWAIT;
                        qcnt_d = 4'(QINJ_DELAY - 1);
                    end
                end
                QWAIT: begin
                    ci_err = cmd[C_QINJ];   // no retrigger while pending
                    if (qcnt_q == '0) begin
                        qinj_d = 1'b1;
                        qst_d  = QIDLE;
                    end else begin
                        qcnt_d = qcnt_q - 4'd1;
                    end
                end
                default: qst_d = QIDLE;
            endcase
        end
    end

    // Datapath next state
    always_comb begin
        // invalidCmd, malformed fcd and rejected ChargeInj share one increment.
        err_event = aligned_q && (inv_q || multi_hot || ci_err);
        err_d     = (err_event && err_q != 8'hFF) ? err_q + 8'd1 : err_q;

        // Load wins over wrap.
        if (bc_load)                    bcid_d = 12'(BCID_OFFSET);
        else if (bcid_q == 12'(BCID_MAX)) bcid_d = '0;
        else                            bcid_d = bcid_q + 12'd1;

        synced_d = synced_q;
        ws_d     = ws_q;
        if (align_fall) begin
            synced_d = 1'b0;
            ws_d     = 1'b0;
        end else begin
            if (bc_load)         synced_d = 1'b1;
            if (cmd[C_WSSTA])    ws_d     = 1'b1;
            else if (cmd[C_WSSTP]) ws_d   = 1'b0;
        end

        l1a_d    = cmd[C_L1A] || cmd[C_L1ABCR] || cmd[C_L1ACR];
        l1acnt_d = l1acnt_q;
        if (cmd[C_L1ACR])                    l1acnt_d = '0;
        else if (cmd[C_L1A] || cmd[C_L1ABCR]) l1acnt_d = l1acnt_q + 8'd1;

        lrst_d = cmd[C_LRST];
        sync_d = cmd[C_SYNC];
    end

    always_ff @(posedge clk40 or posedge reset) begin
        if (reset) begin
            aligned_q      <= 1'b0;
            aligned_prev_q <= 1'b0;
            inv_q          <= 1'b0;
            fcd_q          <= '0;
            bcid_q         <= '0;
            synced_q       <= 1'b0;
            l1a_q          <= 1'b0;
            l1acnt_q       <= '0;
            lrst_q         <= 1'b0;
            sync_q         <= 1'b0;
            qinj_q         <= 1'b0;
            ws_q           <= 1'b0;
            err_q          <= '0;
            qst_q          <= QIDLE;
            qcnt_q         <= '0;
        end else begin
            aligned_q      <= aligned;
            aligned_prev_q <= aligned_q;
            inv_q          <= invalidCmd;
            fcd_q          <= fcd;
            bcid_q         <= bcid_d;
            synced_q       <= synced_d;
            l1a_q          <= l1a_d;
            l1acnt_q       <= l1acnt_d;
            lrst_q         <= lrst_d;
            sync_q         <= sync_d;
            qinj_q         <= qinj_d;
            ws_q           <= ws_d;
            err_q          <= err_d;
            qst_q          <= qst_d;
            qcnt_q         <= qcnt_d;
        end
    end

    assign bcid        = bcid_q;
    assign bcidSynced  = synced_q;
    assign l1a         = l1a_q;
    assign l1aCount    = l1acnt_q;
    assign linkReset   = lrst_q;
    assign syncForTrig = sync_q;
    assign qinj        = qinj_q;
    assign qinjBusy    = (qst_q == QWAIT);
    assign wsActive    = ws_q;
    assign errCount    = err_q;

endmodule

// File: tb/tb_fast_command_executor.sv
module tb_fast_command_executor;

    localparam int BMAX = 3563;
    localparam int BOFF = 0;
    localparam int QD   = 4;

    logic        clk40 = 1'b0;
    logic        reset = 1'b1;
    logic        aligned = 1'b0;
    logic        invalidCmd = 1'b0;
    logic [9:0]  fcd = '0;
    logic [11:0] bcid;
    logic        bcidSynced, l1a, linkReset, syncForTrig, qinj, qinjBusy, wsActive;
    logic [7:0]  l1aCount, errCount;

    fast_command_executor #(.BCID_MAX(BMAX), .BCID_OFFSET(BOFF), .QINJ_DELAY(QD)) dut (
        .clk40(clk40), .reset(reset), .aligned(aligned), .invalidCmd(invalidCmd), .fcd(fcd),
        .bcid(bcid), .bcidSynced(bcidSynced), .l1a(l1a), .l1aCount(l1aCount),
        .linkReset(linkReset), .syncForTrig(syncForTrig), .qinj(qinj), .qinjBusy(qinjBusy),
        .wsActive(wsActive), .errCount(errCount)
    );

    always #5 clk40 = ~clk40;

    int errs = 0;
    int checks = 0;

    // Reference model: commands seen at an edge take effect at the next edge.
    int         m_bcid, m_cnt, m_err, cyc, fire_at;
    bit         m_sync, m_l1a, m_lr, m_sft, m_qinj, m_busy, m_ws, pend;
    bit         p_al, p_inv, prev_al;
    logic [9:0] p_fcd;

    task automatic model_reset();
        m_bcid = 0; m_cnt = 0; m_err = 0; cyc = 0; fire_at = 0;
        m_sync = 0; m_l1a = 0; m_lr = 0; m_sft = 0; m_qinj = 0; m_busy = 0; m_ws = 0;
        pend = 0; p_al = 0; p_inv = 0; prev_al = 0; p_fcd = '0;
    endtask

    task automatic model_edge();
        int  ones;
        bit  ex, fall, pb, er;
        ones = $countones(p_fcd);
        ex   = p_al && ones == 1;
        fall = prev_al && !p_al;
        pb   = pend;
        er   = p_al && (p_inv || ones > 1 || (ex && p_fcd[5] && pb));
        m_l1a = 0; m_lr = 0; m_sft = 0; m_qinj = 0;
        if (fall) begin
            pend = 0; m_ws = 0; m_sync = 0;
        end else if (pend && fire_at == cyc) begin
            m_qinj = 1; pend = 0;
        end
        if (ex && p_fcd[5] && !pb) begin pend = 1; fire_at = cyc + QD; end
        m_busy = pend;
        if (ex && (p_fcd[2] || p_fcd[7])) begin m_bcid = BOFF; m_sync = 1; end
        else m_bcid = (m_bcid == BMAX) ? 0 : m_bcid + 1;
        if (ex && (p_fcd[6] || p_fcd[7])) begin m_l1a = 1; m_cnt = (m_cnt + 1) % 256; end
        if (ex && p_fcd[4]) begin m_l1a = 1; m_cnt = 0; end
        if (ex && p_fcd[1]) m_lr = 1;
        if (ex && p_fcd[3]) m_sft = 1;
        if (ex && p_fcd[8]) m_ws = 1;
        if (ex && p_fcd[9]) m_ws = 0;
        if (er && m_err < 255) m_err++;
        prev_al = p_al; p_al = aligned; p_inv = invalidCmd; p_fcd = fcd;
        cyc++;
    endtask

    // Drive one cycle of inputs, clock it, advance the model, settle 1 time unit.
    task automatic tick(input bit a, input bit inv, input logic [9:0] f);
        aligned = a; invalidCmd = inv; fcd = f;
        @(posedge clk40);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; aligned = 0; invalidCmd = 0; fcd = '0;
        model_reset();
        @(negedge clk40);
        @(negedge clk40);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({bcid, bcidSynced, l1a, l1aCount, linkReset, syncForTrig, qinj, qinjBusy, wsActive, errCount} !== '0) begin
            errs++;
            $display("FAIL reset_state: got bcid=%0d l1aCount=%0d errCount=%0d, expected all zero", bcid, l1aCount, errCount);
        end
    endtask

    task automatic test_bcid_run();
        int maxseen = 0;
        do_reset();
        for (int k = 1; k <= 3570; k++) begin
            tick(1, 0, '0);
            if (int'(bcid) > maxseen) maxseen = int'(bcid);
            checks++;
            if (bcid !== 12'(k % (BMAX + 1)) || bcidSynced !== 1'b0 || {l1a, linkReset, syncForTrig, qinj} !== 4'b0) begin
                errs++;
                $display("FAIL bcid_run k=%0d: got bcid=%0d sync=%b, expected bcid=%0d sync=0", k, bcid, bcidSynced, k % (BMAX + 1));
            end
        end
        checks++;
        if (maxseen != BMAX) begin
            errs++;
            $display("FAIL bcid_max: got %0d expected %0d", maxseen, BMAX);
        end
    endtask

    task automatic test_bcr();
        int guard = 0;
        do_reset();
        for (int k = 0; k < 100; k++) tick(1, 0, '0);
        tick(1, 0, 10'h004);
        tick(1, 0, '0);
        checks++;
        if (bcid !== 12'(BOFF) || bcidSynced !== 1'b1) begin
            errs++;
            $display("FAIL bcr_load: got bcid=%0d sync=%b expected bcid=%0d sync=1", bcid, bcidSynced, BOFF);
        end
        while (bcid != 12'(BMAX - 1) && guard < 5000) begin tick(1, 0, '0); guard++; end
        checks++;
        if (guard >= 5000) begin
            errs++;
            $display("FAIL bcr_wait: timeout got bcid=%0d expected %0d", bcid, BMAX - 1);
        end
        tick(1, 0, 10'h004);   // registered while bcid becomes BMAX
        checks++;
        if (bcid !== 12'(BMAX)) begin
            errs++;
            $display("FAIL bcr_pre_wrap: got %0d expected %0d", bcid, BMAX);
        end
        tick(1, 0, '0);
        checks++;
        if (bcid !== 12'(BOFF)) begin
            errs++;
            $display("FAIL bcr_at_wrap: got %0d expected %0d", bcid, BOFF);
        end
    endtask

    task automatic test_l1a();
        logic [9:0] cmds [7];
        int exp_cnt [7];
        int strobes = 0;
        cmds = '{10'h040, 10'h040, 10'h040, 10'h040, 10'h040, 10'h010, 10'h080};
        exp_cnt = '{1, 2, 3, 4, 5, 0, 1};
        do_reset();
        for (int k = 0; k < 20; k++) tick(1, 0, '0);
        for (int i = 0; i < 8; i++) begin
            tick(1, 0, (i < 7) ? cmds[i] : 10'h000);
            if (l1a) strobes++;
            if (i >= 1) begin
                checks++;
                if (l1a !== 1'b1 || l1aCount !== 8'(exp_cnt[i-1])) begin
                    errs++;
                    $display("FAIL l1a_seq[%0d]: got l1a=%b cnt=%0d expected l1a=1 cnt=%0d", i - 1, l1a, l1aCount, exp_cnt[i-1]);
                end
            end
        end
        checks++;
        if (bcid !== 12'(BOFF) || bcidSynced !== 1'b1) begin
            errs++;
            $display("FAIL l1a_bcr_load: got bcid=%0d sync=%b expected %0d/1", bcid, bcidSynced, BOFF);
        end
        tick(1, 0, '0);
        if (l1a) strobes++;
        checks++;
        if (strobes != 7) begin
            errs++;
            $display("FAIL l1a_strobes: got %0d expected 7", strobes);
        end
    endtask

    task automatic test_qinj();
        int e0;
        do_reset();
        for (int k = 0; k < 5; k++) tick(1, 0, '0);
        e0 = int'(errCount);
        for (int k = 0; k < 8; k++) begin
            tick(1, 0, (k == 0 || k == 2) ? 10'h020 : 10'h000);
            // after tick k, the first ChargeInj has been executed k cycles ago (k>=1)
            checks++;
            if (qinjBusy !== ((k >= 1 && k <= QD) ? 1'b1 : 1'b0) || qinj !== ((k == QD + 1) ? 1'b1 : 1'b0)) begin
                errs++;
                $display("FAIL qinj_t%0d: got busy=%b qinj=%b", k, qinjBusy, qinj);
            end
        end
        checks++;
        if (int'(errCount) != e0 + 1) begin
            errs++;
            $display("FAIL qinj_retrigger_err: got %0d expected %0d", errCount, e0 + 1);
        end
    endtask

    task automatic test_gating();
        int e0;
        do_reset();
        for (int k = 0; k < 3; k++) tick(1, 0, '0);
        e0 = int'(errCount);
        tick(0, 1, 10'h040);
        for (int k = 0; k < 3; k++) begin
            tick(1, 0, '0);
            checks++;
            if (l1a !== 1'b0 || int'(errCount) != e0) begin
                errs++;
                $display("FAIL gated_cmd: got l1a=%b err=%0d expected 0/%0d", l1a, errCount, e0);
            end
        end
        tick(1, 0, 10'h0C0);
        tick(1, 0, '0);
        checks++;
        if (l1a !== 1'b0 || l1aCount !== 8'd0 || int'(errCount) != e0 + 1) begin
            errs++;
            $display("FAIL multi_hot: got l1a=%b cnt=%0d err=%0d expected 0/0/%0d", l1a, l1aCount, errCount, e0 + 1);
        end
        for (int k = 0; k < 300; k++) tick(1, 1, '0);
        tick(1, 0, '0);
        checks++;
        if (errCount !== 8'd255) begin
            errs++;
            $display("FAIL err_saturate: got %0d expected 255", errCount);
        end
    endtask

    task automatic test_align_loss();
        bit saw_qinj = 0;
        do_reset();
        for (int k = 0; k < 3; k++) tick(1, 0, '0);
        tick(1, 0, 10'h004);      // BCR
        tick(1, 0, 10'h100);      // WS_Start
        tick(1, 0, 10'h020);      // ChargeInj
        tick(1, 0, '0);
        checks++;
        if (wsActive !== 1'b1 || qinjBusy !== 1'b1 || bcidSynced !== 1'b1) begin
            errs++;
            $display("FAIL pre_loss: got ws=%b busy=%b sync=%b expected 1/1/1", wsActive, qinjBusy, bcidSynced);
        end
        tick(0, 0, '0);
        tick(0, 0, '0);
        checks++;
        if (wsActive !== 1'b0 || qinjBusy !== 1'b0 || bcidSynced !== 1'b0) begin
            errs++;
            $display("FAIL align_loss: got ws=%b busy=%b sync=%b expected 0/0/0", wsActive, qinjBusy, bcidSynced);
        end
        for (int k = 0; k < 8; k++) begin
            tick(0, 0, '0);
            if (qinj) saw_qinj = 1;
        end
        checks++;
        if (saw_qinj) begin
            errs++;
            $display("FAIL loss_no_qinj: got qinj pulse expected none");
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int k = 0; k < 3; k++) tick(1, 0, '0);
        tick(1, 0, 10'h100);
        tick(1, 0, 10'h020);
        tick(1, 0, 10'h040);
        tick(1, 0, '0);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({bcid, bcidSynced, l1a, l1aCount, linkReset, syncForTrig, qinj, qinjBusy, wsActive, errCount} !== '0) begin
            errs++;
            $display("FAIL reset_mid: got bcid=%0d busy=%b ws=%b cnt=%0d expected all zero", bcid, qinjBusy, wsActive, l1aCount);
        end
        do_reset();
    endtask

    task automatic test_random();
        logic [9:0] f;
        logic [34:0] exp_v, act_v;
        int r;
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            r = int'($urandom_range(0, 9));
            if (r < 6)       f = 10'(1) << $urandom_range(0, 9);
            else if (r < 8)  f = '0;
            else             f = 10'($urandom);
            tick(($urandom_range(0, 19) != 0), ($urandom_range(0, 29) == 0), f);
            exp_v = {12'(m_bcid), m_sync, m_l1a, 8'(m_cnt), m_lr, m_sft, m_qinj, m_busy, m_ws, 8'(m_err)};
            act_v = {bcid, bcidSynced, l1a, l1aCount, linkReset, syncForTrig, qinj, qinjBusy, wsActive, errCount};
            checks++;
            if (act_v !== exp_v) begin
                errs++;
                $display("FAIL random cyc=%0d: got %h expected %h", k, act_v, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_bcid_run();
        test_bcr();
        test_l1a();
        test_qinj();
        test_gating();
        test_align_loss();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/fast_command_executor.md
Name: fast_command_executor

Overview:
- Sits directly downstream of the fast-command decoder, in the 40 MHz domain.
- Consumes the decoder's one-hot command word, alignment flag and invalid-command flag.
- Turns them into the chip-level timing actions: single-cycle strobes, a BCID counter, an L1A event counter, a delayed charge-injection pulse, a waveform-sampler window level, and a saturating command-error counter.
- Commands are acted on only while the decoder reports alignment.

Parameters:
- BCID_MAX, 3563: last BCID value; the counter wraps from BCID_MAX to 0.
- BCID_OFFSET, 0: value loaded into BCID on BCR. Must be ≤ BCID_MAX.
- QINJ_DELAY, 4: clk40 cycles from the ChargeInj strobe to the qinj pulse. Range 1..15.

Ports:
- clk40 in 1: 40 MHz clock
- reset in 1: asynchronous, active-high reset
- aligned in 1: decoder word/bit alignment achieved
- invalidCmd in 1: decoder saw a non-command symbol this cycle
- fcd in 10: one-hot command. Bit assignment:
  - bit0 IDLE, bit1 LinkReset, bit2 BCR, bit3 SyncForTrig, bit4 L1A_CR
  - bit5 ChargeInj, bit6 L1A, bit7 L1A_BCR, bit8 WS_Start, bit9 WS_Stop
- bcid out 12: bunch-crossing counter
- bcidSynced out 1: high once a BCR or L1A_BCR has been executed since the last reset/alignment loss
- l1a out 1: L1A strobe
- l1aCount out 8: L1A event counter
- linkReset out 1: strobe
- syncForTrig out 1: strobe
- qinj out 1: charge-injection pulse
- qinjBusy out 1: charge injection pending
- wsActive out 1: waveform-sampler window level
- errCount out 8: saturating command-error counter

Behaviour:
- Reset (async assert, sync release on clk40): every output is 0; internal qinj delay counter is 0.
- Input stage and latency:
  - aligned, invalidCmd and fcd are registered once.
  - A command present at clk40 edge N produces its effect on outputs after edge N+1 (one-cycle latency).
  - All strobes are exactly one cycle wide.
- Gating:
  - If registered aligned=0, fcd and invalidCmd are ignored; no strobes and no error counting.
  - fcd with 0 bits set: no command, not an error.
  - fcd with >1 bit set: ignored as a command; counted as one error.
  - invalidCmd=1: counts one error even if fcd is also malformed (max one increment per cycle).
- errCount: +1 per error cycle, saturates at 255; cleared only by reset.
- BCID:
  - Free-running every cycle from reset: next = (bcid==BCID_MAX) ? 0 : bcid+1.
  - An executed BCR or L1A_BCR loads BCID_OFFSET instead of incrementing, and sets bcidSynced.
  - BCR coinciding with wrap: the load wins.
- L1A:
  - L1A: l1a=1; l1aCount+1, wrapping 255→0.
  - L1A_BCR: both the L1A action and the BCR action.
  - L1A_CR: l1a=1; l1aCount becomes 0.
- LinkReset, SyncForTrig: pulse the matching strobe only.
- IDLE: no action.
- Charge injection, FSM states QIDLE and QWAIT:
  - QIDLE + ChargeInj → QWAIT; counter loaded with QINJ_DELAY-1; qinjBusy=1.
  - QWAIT: decrement each cycle. On the cycle the counter is 0, qinj=1 for one cycle and FSM → QIDLE (qinjBusy=0 that same cycle).
  - qinj therefore rises exactly QINJ_DELAY cycles after the cycle that ChargeInj would strobe.
  - ChargeInj received in QWAIT is ignored and counts one error. No retrigger.
- Waveform sampler:
  - WS_Start sets wsActive; WS_Stop clears it.
  - Start while active, or stop while inactive: no change, not an error.
- Alignment loss: a falling edge of registered aligned, in the same cycle, does all of the following:
  - clears wsActive and bcidSynced;
  - forces the qinj FSM to QIDLE without emitting qinj.
  - bcid keeps counting; l1aCount and errCount are held.
- Reset mid-operation: all state returns to reset values immediately (asynchronous).

Test Plan:
- Reset, then aligned=1, fcd=0 for 3570 cycles → bcid runs 0..3563 then 0,1,…; bcidSynced=0; no strobes.
- fcd=bit2 (BCR) at cycle 100 with BCID_OFFSET=0 → bcid=0 at cycle 101; bcidSynced=1. Repeat BCR on the cycle bcid==3563 → bcid=0, not 3564.
- Five L1A commands, then L1A_CR, then L1A_BCR → l1a strobes 7×; l1aCount sequence 1,2,3,4,5,0,1; bcid reloads on the L1A_BCR.
- ChargeInj with QINJ_DELAY=4 at cycle 10; second ChargeInj at cycle 12 → qinj single pulse at cycle 15; errCount=1; qinjBusy high cycles 11–14.
- aligned=0 while fcd=bit6 and invalidCmd pulse → no l1a, errCount unchanged. fcd=0x0C0 with aligned=1 → no action, errCount+1. Drive 300 errors → errCount=255.
- WS_Start, ChargeInj, then aligned drops 2 cycles later → wsActive=0, qinjBusy=0, no qinj pulse, bcidSynced=0. Assert reset mid-QWAIT → all outputs 0 immediately.
